// File: rtl/sha256_pkg.sv
// Shared definitions for the pblock array: phase encoding decoded by every pblock,
// SHA-256 round constants and the header/round limits used by the sequencer.
package sha256_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00000,
    ST_PREP1    = 5'b01000,
    ST_COMPUTE1 = 5'b10000,
    ST_PREP2    = 5'b01001,
    ST_COMPUTE2 = 5'b10001,
    ST_PREP31   = 5'b01010,
    ST_PREP32   = 5'b01011,
    ST_COMPUTE3 = 5'b10010,
    ST_WRITE    = 5'b00100
  } pblock_state_t;

  localparam int HDR_WORDS = 20;
  localparam logic [6:0] T_LAST = 7'd65;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Round t uses K[t-1]; t = 0 and the post-round slot t = 65 clamp to the table ends.
  function automatic logic [5:0] k_index(input logic [6:0] t);
    if (t == 7'd0) begin
      return 6'd0;
    end else if (t > 7'd64) begin
      return 6'd63;
    end else begin
      return 6'(t - 7'd1);
    end
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Registered round-constant lookup; output holds its value while en is low.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [6:0]  t,
  output logic [31:0] k
);

  // Constant register, loaded with the entry for the round presented on t.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k <= 32'd0;
    end else if (en) begin
      k <= K[k_index(t)];
    end else begin
      k <= k;
    end
  end

endmodule

// File: rtl/pblock_sequencer.sv
// Sequencer for the parallel-nonce pblock array: drives the shared phase/round/nonce/
// constant buses, fetches header words and writes one H0 result per nonce.
module pblock_sequencer
  import sha256_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NUM_GROUPS = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             message_addr,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [15:0]             mem_addr,
  output logic                    mem_we,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data,
  output logic [4:0]              state,
  output logic [6:0]              t,
  output logic [31:0]             n,
  output logic [31:0]             k1,
  input  logic [NUM_NONCES*32-1:0] hout
);

  localparam int I_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam int G_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [I_W-1:0] IDX_LAST   = I_W'(NUM_NONCES - 1);
  localparam logic [G_W-1:0] GROUP_LAST = G_W'(NUM_GROUPS - 1);
  localparam logic [15:0] BLK2_FIRST = 16'(HDR_WORDS - 4);
  localparam logic [15:0] BLK1_LAST  = 16'd15;

  pblock_state_t   state_r, state_s;
  logic [6:0]      t_r, t_s;
  logic [31:0]     n_r, n_s;
  logic [G_W-1:0]  group_r, group_s;
  logic [I_W-1:0]  idx_r, idx_s;
  logic [15:0]     addr_r, addr_s;
  logic            we_r, we_s;
  logic [31:0]     wdata_r, wdata_s;
  logic            done_r, done_s;
  logic            k_en_s;

  // Header data is consumed by the pblocks themselves, not by the sequencer.
  logic unused_s;
  assign unused_s = ^mem_read_data;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_s = state_r;
    t_s     = 7'd0;
    n_s     = n_r;
    group_s = group_r;
    idx_s   = '0;
    addr_s  = addr_r;
    we_s    = 1'b0;
    wdata_s = wdata_r;
    done_s  = done_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_PREP1;
          done_s  = 1'b0;
          group_s = '0;
          n_s     = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREP1: state_s = ST_COMPUTE1;
      ST_COMPUTE1: begin
        if (t_r == T_LAST) begin
          state_s = ST_PREP2;
        end else begin
          t_s = t_r + 7'd1;
        end
      end
      ST_PREP2: state_s = ST_COMPUTE2;
      ST_COMPUTE2: begin
        if (t_r == T_LAST) begin
          state_s = ST_PREP31;
        end else begin
          t_s = t_r + 7'd1;
        end
      end
      ST_PREP31: state_s = ST_PREP32;
      ST_PREP32: state_s = ST_COMPUTE3;
      ST_COMPUTE3: begin
        if (t_r == T_LAST) begin
          state_s = ST_WRITE;
        end else begin
          t_s = t_r + 7'd1;
        end
      end
      ST_WRITE: begin
        if (idx_r != IDX_LAST) begin
          idx_s = idx_r + I_W'(1);
        end else if (group_r != GROUP_LAST) begin
          state_s = ST_PREP1;
          group_s = group_r + G_W'(1);
          n_s     = n_r + 32'(NUM_NONCES);
        end else begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // Memory port follows the upcoming phase so reads lead the pblock by one cycle.
    case (state_s)
      ST_PREP1: addr_s = message_addr;
      ST_COMPUTE1: begin
        if (t_s < 7'(BLK1_LAST)) begin
          addr_s = message_addr + 16'(t_s) + 16'd1;
        end else begin
          addr_s = addr_r;
        end
      end
      ST_PREP2: addr_s = message_addr + BLK2_FIRST;
      ST_COMPUTE2: begin
        if (t_s < 7'd2) begin
          addr_s = message_addr + BLK2_FIRST + 16'(t_s) + 16'd1;
        end else begin
          addr_s = addr_r;
        end
      end
      ST_WRITE: begin
        addr_s  = output_addr + n_s[15:0] + 16'(idx_s);
        we_s    = 1'b1;
        wdata_s = hout[32*int'(idx_s) +: 32];
      end
      default: addr_s = addr_r;
    endcase

    k_en_s = state_s[4] | state_s[3];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      t_r     <= 7'd0;
      n_r     <= 32'd0;
      group_r <= '0;
      idx_r   <= '0;
      addr_r  <= 16'd0;
      we_r    <= 1'b0;
      wdata_r <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      n_r     <= n_s;
      group_r <= group_s;
      idx_r   <= idx_s;
      addr_r  <= addr_s;
      we_r    <= we_s;
      wdata_r <= wdata_s;
      done_r  <= done_s;
    end
  end

  sha256_k_rom u_k_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (k_en_s),
    .t       (t_s),
    .k       (k1)
  );

  assign state          = state_r;
  assign t              = t_r;
  assign n              = n_r;
  assign mem_addr       = addr_r;
  assign mem_we         = we_r;
  assign mem_write_data = wdata_r;
  assign done           = done_r;

endmodule

// File: tb/tb_pblock_sequencer.sv
// Directed bench for pblock_sequencer: single-group and two-group instances,
// cycle-by-cycle comparison against a hand-written phase/address table.
module tb_pblock_sequencer;

  localparam int NN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, start1, start2, sel;
  logic [15:0]       message_addr, output_addr;
  logic [31:0]       mem_read_data;
  logic [NN*32-1:0]  hout;

  logic        done1, we1, done2, we2;
  logic [15:0] addr1, addr2;
  logic [31:0] wd1, wd2, n1, n2, k1_1, k1_2;
  logic [4:0]  st1, st2;
  logic [6:0]  t1, t2;

  logic        o_done, o_we;
  logic [15:0] o_addr;
  logic [31:0] o_wd, o_n, o_k1;
  logic [4:0]  o_st;
  logic [6:0]  o_t;

  int checks = 0;
  int errors = 0;

  pblock_sequencer #(.NUM_NONCES(NN), .NUM_GROUPS(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done1), .mem_addr(addr1), .mem_we(we1), .mem_write_data(wd1),
    .mem_read_data(mem_read_data), .state(st1), .t(t1), .n(n1), .k1(k1_1),
    .hout(hout)
  );

  pblock_sequencer #(.NUM_NONCES(NN), .NUM_GROUPS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done2), .mem_addr(addr2), .mem_we(we2), .mem_write_data(wd2),
    .mem_read_data(mem_read_data), .state(st2), .t(t2), .n(n2), .k1(k1_2),
    .hout(hout)
  );

  assign o_done = sel ? done2 : done1;
  assign o_we   = sel ? we2   : we1;
  assign o_addr = sel ? addr2 : addr1;
  assign o_wd   = sel ? wd2   : wd1;
  assign o_n    = sel ? n2    : n1;
  assign o_k1   = sel ? k1_2  : k1_1;
  assign o_st   = sel ? st2   : st1;
  assign o_t    = sel ? t2    : t1;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic exp_done);
    check_value("idle_state", 64'(o_st), 64'h0);
    check_value("idle_we", 64'(o_we), 64'h0);
    check_value("idle_t", 64'(o_t), 64'h0);
    check_value("idle_done", 64'(o_done), 64'(exp_done));
  endtask

  // Walks one group, cycle c = 0 being the first PREP1 cycle.
  task automatic run_group(input logic [15:0] oaddr, input logic [31:0] n_exp,
                           input int last_cyc, input bit poke);
    logic [4:0]  es;
    logic [6:0]  et;
    logic [15:0] ea;
    logic        ewe;
    for (int c = 0; c <= last_cyc; c++) begin
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      ewe = 1'b0;
      et  = 7'd0;
      ea  = message_addr + 16'd18;
      if (c == 0) begin
        es = 5'b01000; ea = message_addr;
      end else if (c <= 66) begin
        es = 5'b10000; et = 7'(c - 1);
        ea = (c <= 15) ? message_addr + 16'(c) : message_addr + 16'd15;
      end else if (c == 67) begin
        es = 5'b01001; ea = message_addr + 16'd16;
      end else if (c <= 133) begin
        es = 5'b10001; et = 7'(c - 68);
        ea = (c == 68) ? message_addr + 16'd17 : message_addr + 16'd18;
      end else if (c == 134) begin
        es = 5'b01010;
      end else if (c == 135) begin
        es = 5'b01011;
      end else if (c <= 201) begin
        es = 5'b10010; et = 7'(c - 136);
      end else begin
        es = 5'b00100; ewe = 1'b1;
        ea = oaddr + n_exp[15:0] + 16'(c - 202);
      end
      check_value("state", 64'(o_st), 64'(es));
      check_value("t", 64'(o_t), 64'(et));
      check_value("mem_addr", 64'(o_addr), 64'(ea));
      check_value("mem_we", 64'(o_we), 64'(ewe));
      check_value("n", 64'(o_n), 64'(n_exp));
      check_value("done_busy", 64'(o_done), 64'h0);
      if (ewe) check_value("wdata", 64'(o_wd), 64'(32'hC0DE0000 + 32'(c - 202)));
      if (es[3] || (es[4] && et == 7'd1)) check_value("k1_first", 64'(o_k1), 64'h428a2f98);
      if (es[4] && et == 7'd2) check_value("k1_second", 64'(o_k1), 64'h71374491);
      if (es[4] && et >= 7'd64) check_value("k1_last", 64'(o_k1), 64'hc67178f2);
      if (poke && c == 11) begin
        if (sel) start2 = 1'b1;
        else start1 = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
    message_addr = 16'h0000; output_addr = 16'h0040; mem_read_data = 32'h0;
    for (int i = 0; i < NN; i++) hout[32*i +: 32] = 32'hC0DE0000 + 32'(i);

    for (int r = 0; r < 3; r++) begin
      tick();
      check_value("rst_state", 64'(st1), 64'h0);
      check_value("rst_t", 64'(t1), 64'h0);
      check_value("rst_n", 64'(n1), 64'h0);
      check_value("rst_k1", 64'(k1_1), 64'h0);
      check_value("rst_addr", 64'(addr1), 64'h0);
      check_value("rst_we", 64'(we1), 64'h0);
      check_value("rst_wdata", 64'(wd1), 64'h0);
      check_value("rst_done", 64'(done1), 64'h0);
      check_value("rst_state2", 64'(st2), 64'h0);
    end
    reset_n = 1'b1;
    tick();
    check_idle(1'b0);
    check_value("idle_k1", 64'(k1_1), 64'h0);

    // Full run with a stray start pulse at COMPUTE1 t=10.
    start1 = 1'b1;
    run_group(16'h0040, 32'd0, 217, 1'b1);
    tick();
    check_idle(1'b1);
    tick();
    check_idle(1'b1);

    // Restart from done, then abort at COMPUTE2 t=30.
    start1 = 1'b1;
    run_group(16'h0040, 32'd0, 98, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle(1'b0);

    // Post-abort run with the result window wrapping past 0xFFFF.
    output_addr = 16'hFFF8;
    start1 = 1'b1;
    run_group(16'hFFF8, 32'd0, 217, 1'b0);
    tick();
    check_idle(1'b1);

    // Two-group instance: second group uses n = 16.
    sel = 1'b1;
    output_addr = 16'h0040;
    start2 = 1'b1;
    run_group(16'h0040, 32'd0, 217, 1'b0);
    run_group(16'h0040, 32'd16, 217, 1'b0);
    tick();
    check_idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pblock_sequencer.md
# pblock_sequencer

Controller that sequences the array of parallel-nonce SHA-256 pblocks in the bitcoin-hash design. It reads the 20-word block header from memory, drives the shared `state`, `t`, `n` and `k1` buses that every pblock samples, and collects the per-nonce `hout` results. It writes one result word per nonce back to memory, repeating for `NUM_GROUPS` groups of `NUM_NONCES` nonces.

## Interface
- `NUM_NONCES`, default 16: number of pblock instances, i.e. nonces per group.
- `NUM_GROUPS`, default 1: nonce groups per `start`; total nonces are `NUM_NONCES*NUM_GROUPS`.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: level-sampled in IDLE; begins a run.
- `message_addr`  in  16: word address of header word 0.
- `output_addr`  in  16: word address of the result for nonce 0.
- `done`  out  1: high from the end of the run until the next accepted `start`.
- `mem_addr`  out  16: memory word address.
- `mem_we`  out  1: write strobe.
- `mem_write_data`  out  32: write data.
- `mem_read_data`  in  32: read data; 1-cycle latency.
- `state`  out  5: pblock phase bus.
- `t`  out  7: round counter bus.
- `n`  out  32: nonce base for the group; pblock i uses `n+i`.
- `k1`  out  32: round constant bus.
- `hout`  in  `NUM_NONCES*32`: packed H0 results; nonce i occupies bits `[32i+31:32i]`.

## Operation
State encoding, fixed because pblock decodes the bits:
- IDLE 00000, PREP1 01000, COMPUTE1 10000.
- PREP2 01001, COMPUTE2 10001.
- PREP31 01010, PREP32 01011, COMPUTE3 10010.
- WRITE 00100.

Transitions:
- IDLE → PREP1 on `start`. This clears `done`, sets group = 0 and `n` = 0.
- PREP1 → COMPUTE1.
- COMPUTE1 → PREP2 when t = 65.
- PREP2 → COMPUTE2.
- COMPUTE2 → PREP31 when t = 65.
- PREP31 → PREP32 → COMPUTE3.
- COMPUTE3 → WRITE when t = 65.
- WRITE → PREP1 after `NUM_NONCES` writes if group < `NUM_GROUPS`−1. This increments group and adds `NUM_NONCES` to `n`.
- Otherwise WRITE → IDLE, setting `done`.

Counter `t`:
- In every COMPUTE state, `t` counts 0..65, then resets to 0 on exit.
- In PREP states `t` = 0.

Round constant:
- `k1` = K[0] when t = 0 and in PREP states.
- `k1` = K[t−1] for t = 1..64.
- `k1` holds K[63] at t = 65.

Memory reads, one cycle ahead (read address issued at cycle c, data valid at c+1):
- Block 1, header words 0..15: word 0 is issued in PREP1 and word j+1 while t = j, for j = 0..14.
- Block 2, header words 16..18: word 16 is issued in PREP2, words 17..18 at t = 0..1.
- Otherwise `mem_addr` holds its last value.
- No reads are issued in COMPUTE3; its data comes from pblock-internal h2.

WRITE:
- Write index i runs 0..`NUM_NONCES`−1, one per cycle.
- `mem_addr` = `output_addr` + `n` + i, with wrap-around modulo 2^16.
- `mem_we` = 1; `mem_write_data` = `hout[32i+:32]`.

Arithmetic and other rules:
- `n` and address sums wrap modulo their width; no saturation.
- `start` outside IDLE is ignored.
- `start` held high in IDLE after completion starts a new run and clears `done`.

## Timing
- Reset values: `state` = IDLE, `t` = 0, `n` = 0, `k1` = 0, `mem_addr` = 0, `mem_we` = 0, `mem_write_data` = 0, `done` = 0, group = 0, i = 0.
- Reset mid-operation returns to IDLE at the next edge and drops `mem_we` in that same edge. Partial results are not written.
- Per-group cycles: 1 + 66 + 1 + 66 + 2 + 66 + `NUM_NONCES` = 202 + `NUM_NONCES`; 218 at the default.
- From `start` sampled in IDLE, the first PREP1 cycle is the next cycle.
- `done` rises the cycle after the last write; `mem_we` is 0 in that cycle.
- All outputs are registered; no combinational path from `mem_read_data` or `hout` to outputs.
- `hout` is sampled in WRITE only. It is stable there because pblock freezes at t = 65.

## Structure
- Shared package `sha256_pkg` holds:
  - the state-encoding typedef enum `pblock_state_t` (values above);
  - `K[64]` round constants;
  - the header length constant `HDR_WORDS` = 20;
  - the terminal round constant `T_LAST` = 65.
- Sub-module `sha256_k_rom`: registered 64×32 lookup, address = t−1 clamped to 0..63. The sequencer aligns its address one cycle ahead so `k1` meets the rule above.
- Everything else lives in one FSM plus counters in `pblock_sequencer`.

## Test plan
- **Reset and idle.** Hold `reset_n` = 0 for 3 cycles, `start` = 0. All outputs must be 0 and `state` = 00000 for every cycle.
- **Full run.** `message_addr` = 0x0000, `output_addr` = 0x0040, `start` pulse.
  - Check `state` sequence and dwell: 1/66/1/66/1/1/66/16.
  - Check `done` high exactly 218 cycles after the first PREP1.
  - Check writes to 0x0040..0x004F carry `hout` slices 0..15.
- **Memory reads and constants.** In the full run, check the read addresses issued for header words 0..18 and their cycles as specified. Check `k1` = 0x428a2f98 at t = 1 and 0xc67178f2 at t = 64 in all three COMPUTE phases.
- **Multiple groups.** `NUM_GROUPS` = 2.
  - Check `n` = 0 for the first group, then 16.
  - Check the second WRITE targets 0x0050..0x005F.
  - Check total run length 436 cycles.
- **Abort and ignore.** Deassert `reset_n` for one cycle at COMPUTE2 t = 30. Next cycle `state` = IDLE and `mem_we` = 0. A new `start` then completes normally. Also pulse `start` at COMPUTE1 t = 10 during a run; there must be no effect.
- **Address wrap.** `output_addr` = 0xFFF8. Writes must go to 0xFFF8..0xFFFF, then 0x0000..0x0007.
